// File: rtl/net_pkg.sv
// net_pkg: shared stream widths, arbiter state type and round-robin pick helper
package net_pkg;

    localparam int NET_DATA_WIDTH = 512;
    localparam int NET_KEEP_WIDTH = NET_DATA_WIDTH / 8;
    localparam int NET_USER_WIDTH = 8;
    localparam int NET_DEST_WIDTH = 8;
    localparam int NET_MAX_SRC    = 8;

    typedef enum logic [0:0] {ARB_IDLE, ARB_BUSY} arb_state_t;

    // First asserted request at or after ptr, wrapping at n; returns ptr when nothing is requested
    function automatic logic [2:0] rr_next(input logic [NET_MAX_SRC-1:0] req, input logic [2:0] ptr, input int n);
        logic [2:0] pick;
        logic       found;
        int         j;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < NET_MAX_SRC; i++) begin
            j = int'(ptr) + i;
            if (j >= n) j = j - n;
            if (i < n && !found && req[3'(j)]) begin
                pick  = 3'(j);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// axis_reg_slice: single-entry AXI-stream register with pass-through ready
module axis_reg_slice
    import net_pkg::*;
#(
    parameter int DATA_WIDTH = NET_DATA_WIDTH,
    parameter int KEEP_WIDTH = NET_KEEP_WIDTH,
    parameter int USER_WIDTH = NET_USER_WIDTH,
    parameter int DEST_WIDTH = NET_DEST_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic [KEEP_WIDTH-1:0] s_keep,
    input  logic [USER_WIDTH-1:0] s_user,
    input  logic [DEST_WIDTH-1:0] s_dest,
    input  logic                  s_last,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [KEEP_WIDTH-1:0] m_keep,
    output logic [USER_WIDTH-1:0] m_user,
    output logic [DEST_WIDTH-1:0] m_dest,
    output logic                  m_last,
    output logic                  m_valid,
    input  logic                  m_ready
);

    assign s_ready = !m_valid || m_ready;

    // Load on handshake; drain when the downstream takes the beat and nothing replaces it
    always_ff @(posedge clk) begin
        if (rst) begin
            m_data  <= '0;
            m_keep  <= '0;
            m_user  <= '0;
            m_dest  <= '0;
            m_last  <= 1'b0;
            m_valid <= 1'b0;
        end else if (s_valid && s_ready) begin
            m_data  <= s_data;
            m_keep  <= s_keep;
            m_user  <= s_user;
            m_dest  <= s_dest;
            m_last  <= s_last;
            m_valid <= 1'b1;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/net_tx_arb.sv
// net_tx_arb: round-robin whole-frame arbiter onto the shared network transmit stream
module net_tx_arb
    import net_pkg::*;
#(
    parameter int NUM_SRC         = 4,
    parameter int AXIS_DATA_WIDTH = NET_DATA_WIDTH,
    parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
    parameter int AXIS_USER_WIDTH = NET_USER_WIDTH,
    parameter int AXIS_DEST_WIDTH = NET_DEST_WIDTH,
    parameter int CNT_WIDTH       = 32,
    localparam int GW             = $clog2(NUM_SRC)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_SRC*AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [NUM_SRC*AXIS_KEEP_WIDTH-1:0]   s_axis_tkeep,
    input  logic [NUM_SRC*AXIS_USER_WIDTH-1:0]   s_axis_tuser,
    input  logic [NUM_SRC-1:0]                   s_axis_tlast,
    input  logic [NUM_SRC-1:0]                   s_axis_tvalid,
    output logic [NUM_SRC-1:0]                   s_axis_tready,
    output logic [AXIS_DATA_WIDTH-1:0]           m_axis_tdata,
    output logic [AXIS_KEEP_WIDTH-1:0]           m_axis_tkeep,
    output logic [AXIS_USER_WIDTH-1:0]           m_axis_tuser,
    output logic [AXIS_DEST_WIDTH-1:0]           m_axis_tdest,
    output logic                                 m_axis_tlast,
    output logic                                 m_axis_tvalid,
    input  logic                                 m_axis_tready,
    output logic [GW-1:0]                        grant_idx,
    output logic                                 busy,
    output logic [CNT_WIDTH-1:0]                 frame_cnt,
    output logic [CNT_WIDTH-1:0]                 beat_cnt
);

    arb_state_t                 state;
    logic [GW-1:0]              rr_ptr;
    logic [AXIS_DATA_WIDTH-1:0] sel_data;
    logic [AXIS_KEEP_WIDTH-1:0] sel_keep;
    logic [AXIS_USER_WIDTH-1:0] sel_user;
    logic                       sel_last;
    logic                       sel_valid;
    logic                       slice_ready;
    logic                       in_hs;
    logic                       out_hs;

    assign sel_valid = (state == ARB_BUSY) && s_axis_tvalid[grant_idx];
    assign in_hs     = sel_valid && slice_ready;
    assign out_hs    = m_axis_tvalid && m_axis_tready;
    assign busy      = (state == ARB_BUSY) || m_axis_tvalid;

    // Route the granted source's beat toward the output register
    always_comb begin
        sel_data = '0;
        sel_keep = '0;
        sel_user = '0;
        sel_last = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_idx == GW'(i)) begin
                sel_data = s_axis_tdata[i*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
                sel_keep = s_axis_tkeep[i*AXIS_KEEP_WIDTH +: AXIS_KEEP_WIDTH];
                sel_user = s_axis_tuser[i*AXIS_USER_WIDTH +: AXIS_USER_WIDTH];
                sel_last = s_axis_tlast[i];
            end
        end
    end

    // Only the granted source sees ready, and only while its frame is open
    always_comb begin
        s_axis_tready            = '0;
        s_axis_tready[grant_idx] = (state == ARB_BUSY) && slice_ready;
    end

    // Hold a grant for a whole frame, then move the pointer past the winner once its tlast is taken
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ARB_IDLE;
            rr_ptr    <= '0;
            grant_idx <= '0;
        end else if (state == ARB_IDLE) begin
            if (|s_axis_tvalid) begin
                grant_idx <= GW'(rr_next(NET_MAX_SRC'(s_axis_tvalid), 3'(rr_ptr), NUM_SRC));
                state     <= ARB_BUSY;
            end
        end else if (in_hs && sel_last) begin
            state  <= ARB_IDLE;
            rr_ptr <= (grant_idx == GW'(NUM_SRC - 1)) ? '0 : grant_idx + GW'(1);
        end
    end

    // Statistics count beats and frames as the downstream accepts them
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
            beat_cnt  <= '0;
        end else if (out_hs) begin
            beat_cnt  <= beat_cnt + CNT_WIDTH'(1);
            if (m_axis_tlast) frame_cnt <= frame_cnt + CNT_WIDTH'(1);
        end
    end

    axis_reg_slice #(
        .DATA_WIDTH (AXIS_DATA_WIDTH),
        .KEEP_WIDTH (AXIS_KEEP_WIDTH),
        .USER_WIDTH (AXIS_USER_WIDTH),
        .DEST_WIDTH (AXIS_DEST_WIDTH)
    ) u_out (
        .clk     (clk),
        .rst     (rst),
        .s_data  (sel_data),
        .s_keep  (sel_keep),
        .s_user  (sel_user),
        .s_dest  (AXIS_DEST_WIDTH'(grant_idx)),
        .s_last  (sel_last),
        .s_valid (sel_valid),
        .s_ready (slice_ready),
        .m_data  (m_axis_tdata),
        .m_keep  (m_axis_tkeep),
        .m_user  (m_axis_tuser),
        .m_dest  (m_axis_tdest),
        .m_last  (m_axis_tlast),
        .m_valid (m_axis_tvalid),
        .m_ready (m_axis_tready)
    );

endmodule

// File: tb/tb_net_tx_arb.sv
// tb_net_tx_arb: randomized frame-level checking of the transmit arbiter against a round-robin model
module tb_net_tx_arb;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int KW = DW / 8;
    localparam int UW = 8;
    localparam int TW = 8;
    localparam int CW = 32;

    typedef struct packed {logic [DW-1:0] d; logic [KW-1:0] k; logic [UW-1:0] u; logic l;} beat_t;
    typedef struct packed {logic [DW-1:0] d; logic [KW-1:0] k; logic [UW-1:0] u; logic l; logic [TW-1:0] t;} obeat_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N*DW-1:0]   s_tdata = '0;
    logic [N*KW-1:0]   s_tkeep = '0;
    logic [N*UW-1:0]   s_tuser = '0;
    logic [N-1:0]      s_tlast = '0;
    logic [N-1:0]      s_tvalid = '0;
    logic [N-1:0]      s_tready;
    logic [DW-1:0]     m_tdata;
    logic [KW-1:0]     m_tkeep;
    logic [UW-1:0]     m_tuser;
    logic [TW-1:0]     m_tdest;
    logic              m_tlast;
    logic              m_tvalid;
    logic              m_tready = 1'b1;
    logic [1:0]        grant_idx;
    logic              busy;
    logic [CW-1:0]     frame_cnt;
    logic [CW-1:0]     beat_cnt;

    net_tx_arb #(
        .NUM_SRC(N), .AXIS_DATA_WIDTH(DW), .AXIS_KEEP_WIDTH(KW),
        .AXIS_USER_WIDTH(UW), .AXIS_DEST_WIDTH(TW), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tuser(s_tuser),
        .s_axis_tlast(s_tlast), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tuser(m_tuser),
        .m_axis_tdest(m_tdest), .m_axis_tlast(m_tlast), .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready),
        .grant_idx(grant_idx), .busy(busy), .frame_cnt(frame_cnt), .beat_cnt(beat_cnt)
    );

    always #5 clk = ~clk;

    beat_t  src_q[N][$];
    beat_t  exp_src[N][$];
    int     frm_len[N][$];
    obeat_t exp_q[$];
    obeat_t out_q[$];
    int     out_cyc[$];
    int     stall_cnt[N];
    logic   mid[N];
    logic   rdy_pat[$];
    int     rdy_mode;
    logic   rnd_drop;
    obeat_t held;
    logic   held_v;
    int     cyc;
    int     n_vec = 0;
    int     n_err = 0;

    task automatic add_frame(input int s, input int len);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.d = $urandom;
            b.k = KW'($urandom);
            b.u = UW'($urandom);
            b.l = (i == len - 1);
            src_q[s].push_back(b);
            exp_src[s].push_back(b);
        end
        frm_len[s].push_back(len);
    endtask

    // Round-robin model: whole frames in order, first pending source at or after the pointer wins
    task automatic build_exp(input int start, output int nxt);
        int p, pick, len;
        p = start;
        forever begin
            pick = -1;
            for (int o = 0; o < N; o++)
                if (pick < 0 && frm_len[(p + o) % N].size() > 0) pick = (p + o) % N;
            if (pick < 0) break;
            len = frm_len[pick].pop_front();
            repeat (len) exp_q.push_back({exp_src[pick].pop_front(), TW'(pick)});
            p = (pick + 1) % N;
        end
        nxt = p;
    endtask

    task automatic drive();
        beat_t b;
        for (int i = 0; i < N; i++) begin
            b = (src_q[i].size() > 0) ? src_q[i][0] : '0;
            s_tvalid[i] = src_q[i].size() > 0 && stall_cnt[i] == 0 &&
                          !(rnd_drop && mid[i] && $urandom_range(3) == 0);
            s_tdata[i*DW +: DW] = b.d;
            s_tkeep[i*KW +: KW] = b.k;
            s_tuser[i*UW +: UW] = b.u;
            s_tlast[i] = b.l;
        end
        if (rdy_mode == 0) m_tready = 1'b1;
        else if (rdy_mode == 1) m_tready = 1'($urandom_range(1));
        else if (rdy_pat.size() > 0) m_tready = rdy_pat.pop_front();
        else m_tready = 1'b1;
    endtask

    task automatic step();
        logic [N-1:0] hs;
        obeat_t cur;
        beat_t b;
        @(negedge clk);
        cur = {m_tdata, m_tkeep, m_tuser, m_tlast, m_tdest};
        n_vec++;
        if (!$onehot0(s_tready)) begin
            n_err++;
            $display("FAIL tready_onehot cyc %0d got %b want one-hot or zero", cyc, s_tready);
        end
        if (held_v) begin
            n_vec++;
            if (cur !== held || m_tvalid !== 1'b1) begin
                n_err++;
                $display("FAIL hold_stable cyc %0d got %h valid %b want %h valid 1", cyc, cur, m_tvalid, held);
            end
        end
        if (m_tvalid && !m_tready) begin
            n_vec++;
            if (s_tready !== '0) begin
                n_err++;
                $display("FAIL stall_tready cyc %0d got %b want 0", cyc, s_tready);
            end
        end
        held_v = m_tvalid && !m_tready;
        held = cur;
        hs = s_tvalid & s_tready;
        if (m_tvalid && m_tready) begin
            out_q.push_back(cur);
            out_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (hs[i]) begin
                b = src_q[i].pop_front();
                mid[i] = !b.l;
            end
            if (stall_cnt[i] > 0) stall_cnt[i]--;
        end
        drive();
    endtask

    function automatic logic drained();
        for (int i = 0; i < N; i++) if (src_q[i].size() > 0) return 1'b0;
        return out_q.size() >= exp_q.size() && !m_tvalid;
    endfunction

    task automatic run(input int max);
        int k;
        k = 0;
        while (k < max && !drained()) begin
            step();
            k++;
        end
        n_vec++;
        if (!drained()) begin
            n_err++;
            $display("FAIL drain_timeout got %0d beats want %0d within %0d cycles", out_q.size(), exp_q.size(), max);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            src_q[i].delete();
            exp_src[i].delete();
            frm_len[i].delete();
            mid[i] = 1'b0;
            stall_cnt[i] = 0;
        end
        exp_q.delete();
        out_q.delete();
        out_cyc.delete();
        rdy_pat.delete();
        rdy_mode = 0;
        rnd_drop = 1'b0;
        held_v = 1'b0;
        drive();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s_tvalid = '1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        n_vec++;
        if ({m_tvalid, m_tlast, m_tdata, m_tkeep, m_tuser, m_tdest} !== '0) begin
            n_err++;
            $display("FAIL reset_out got v%b l%b d%h k%h u%h t%h want all 0", m_tvalid, m_tlast, m_tdata, m_tkeep, m_tuser, m_tdest);
        end
        n_vec++;
        if (s_tready !== '0) begin n_err++; $display("FAIL reset_tready got %b want 0", s_tready); end
        n_vec++;
        if (frame_cnt !== '0 || beat_cnt !== '0) begin
            n_err++;
            $display("FAIL reset_cnt got %0d/%0d want 0/0", frame_cnt, beat_cnt);
        end
        n_vec++;
        if (busy !== 1'b0 || grant_idx !== 2'd0) begin
            n_err++;
            $display("FAIL reset_status got busy %b grant %0d want 0 0", busy, grant_idx);
        end
        do_reset();
    endtask

    task automatic test_single_frame();
        int p;
        int want_cyc[3];
        want_cyc = '{2, 3, 4};
        do_reset();
        add_frame(0, 3);
        build_exp(0, p);
        drive();
        run(40);
        n_vec++;
        if (out_q.size() != 3) begin n_err++; $display("FAIL single_count got %0d want 3", out_q.size()); end
        for (int i = 0; i < 3 && i < out_q.size(); i++) begin
            n_vec++;
            if (out_q[i] !== exp_q[i] || out_cyc[i] != want_cyc[i]) begin
                n_err++;
                $display("FAIL single_beat%0d got %h @%0d want %h @%0d", i, out_q[i], out_cyc[i], exp_q[i], want_cyc[i]);
            end
        end
        n_vec++;
        if (frame_cnt !== 32'd1 || beat_cnt !== 32'd3) begin
            n_err++;
            $display("FAIL single_cnt got %0d/%0d want 1/3", frame_cnt, beat_cnt);
        end
    endtask

    task automatic test_round_robin();
        int p;
        do_reset();
        for (int f = 0; f < 2; f++) for (int s = 0; s < N; s++) add_frame(s, 2);
        build_exp(0, p);
        drive();
        run(100);
        n_vec++;
        if (out_q.size() != exp_q.size()) begin n_err++; $display("FAIL rr_count got %0d want %0d", out_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            n_vec++;
            if (out_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rr_beat%0d got %h want %h", i, out_q[i], exp_q[i]); end
        end
        n_vec++;
        if (frame_cnt !== 32'd8 || beat_cnt !== 32'd16 || grant_idx !== 2'(p - 1)) begin
            n_err++;
            $display("FAIL rr_cnt got %0d/%0d grant %0d want 8/16 grant %0d", frame_cnt, beat_cnt, grant_idx, p - 1);
        end
    endtask

    task automatic test_backpressure();
        int p;
        int want_cyc[4];
        want_cyc = '{2, 5, 6, 7};
        do_reset();
        add_frame(0, 4);
        build_exp(0, p);
        rdy_mode = 2;
        rdy_pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        drive();
        run(40);
        n_vec++;
        if (out_q.size() != 4) begin n_err++; $display("FAIL bp_count got %0d want 4", out_q.size()); end
        for (int i = 0; i < 4 && i < out_q.size(); i++) begin
            n_vec++;
            if (out_q[i] !== exp_q[i] || out_cyc[i] != want_cyc[i]) begin
                n_err++;
                $display("FAIL bp_beat%0d got %h @%0d want %h @%0d", i, out_q[i], out_cyc[i], exp_q[i], want_cyc[i]);
            end
        end
    endtask

    task automatic test_src_stall();
        int p, k;
        do_reset();
        add_frame(1, 4);
        add_frame(2, 2);
        build_exp(0, p);
        drive();
        k = 0;
        while (src_q[1].size() > 3 && k < 20) begin step(); k++; end
        stall_cnt[1] = 3;
        drive();
        repeat (3) begin
            step();
            n_vec++;
            if (grant_idx !== 2'd1 || s_tready[2] !== 1'b0) begin
                n_err++;
                $display("FAIL stall_grant got grant %0d tready %b want grant 1 tready[2]=0", grant_idx, s_tready);
            end
        end
        run(60);
        n_vec++;
        if (out_q.size() != exp_q.size()) begin n_err++; $display("FAIL stall_count got %0d want %0d", out_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            n_vec++;
            if (out_q[i] !== exp_q[i]) begin n_err++; $display("FAIL stall_beat%0d got %h want %h", i, out_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_wrap();
        int p;
        do_reset();
        add_frame(2, 2);
        build_exp(0, p);
        drive();
        run(40);
        add_frame(0, 2);
        add_frame(3, 2);
        build_exp(p, p);
        drive();
        run(60);
        n_vec++;
        if (out_q.size() != 6) begin n_err++; $display("FAIL wrap_count got %0d want 6", out_q.size()); end
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            n_vec++;
            if (out_q[i] !== exp_q[i]) begin n_err++; $display("FAIL wrap_beat%0d got %h want %h", i, out_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_mid_reset();
        int p, k;
        do_reset();
        add_frame(0, 4);
        drive();
        k = 0;
        while (src_q[0].size() > 2 && k < 20) begin step(); k++; end
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if (m_tvalid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_out got valid %b busy %b want 0 0", m_tvalid, busy);
        end
        n_vec++;
        if (frame_cnt !== '0 || beat_cnt !== '0) begin
            n_err++;
            $display("FAIL midrst_cnt got %0d/%0d want 0/0", frame_cnt, beat_cnt);
        end
        n_vec++;
        if (s_tready !== '0) begin n_err++; $display("FAIL midrst_tready got %b want 0", s_tready); end
        do_reset();
        add_frame(1, 2);
        build_exp(0, p);
        drive();
        run(40);
        n_vec++;
        if (out_q.size() != 2) begin n_err++; $display("FAIL midrst_count got %0d want 2", out_q.size()); end
        for (int i = 0; i < 2 && i < out_q.size(); i++) begin
            n_vec++;
            if (out_q[i] !== exp_q[i]) begin n_err++; $display("FAIL midrst_beat%0d got %h want %h", i, out_q[i], exp_q[i]); end
        end
        n_vec++;
        if (frame_cnt !== 32'd1 || beat_cnt !== 32'd2) begin
            n_err++;
            $display("FAIL midrst_cnt2 got %0d/%0d want 1/2", frame_cnt, beat_cnt);
        end
    endtask

    task automatic test_random();
        int p, nf, nframes;
        for (int it = 0; it < 4; it++) begin
            do_reset();
            nframes = 0;
            for (int s = 0; s < N; s++) begin
                nf = $urandom_range(1, 3);
                for (int f = 0; f < nf; f++) add_frame(s, $urandom_range(1, 5));
                nframes += nf;
            end
            build_exp(0, p);
            rdy_mode = 1;
            rnd_drop = 1'b1;
            drive();
            run(2000);
            n_vec++;
            if (out_q.size() != exp_q.size()) begin
                n_err++;
                $display("FAIL rand%0d_count got %0d want %0d", it, out_q.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
                n_vec++;
                if (out_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rand%0d_beat%0d got %h want %h", it, i, out_q[i], exp_q[i]); end
            end
            n_vec++;
            if (frame_cnt !== CW'(nframes) || beat_cnt !== CW'(exp_q.size()) || busy !== 1'b0) begin
                n_err++;
                $display("FAIL rand%0d_cnt got %0d/%0d busy %b want %0d/%0d busy 0", it, frame_cnt, beat_cnt, busy, nframes, exp_q.size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_round_robin();
        test_backpressure();
        test_src_stall();
        test_wrap();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
